dom1_skinny_rnd_ctrl: RTL and testbench
=======================================

# dom1_skinny_rnd_ctrl

Round controller and state-share register for the first-order DOM SKINNY-128-384+ datapath. It sits directly upstream of the masked round function. It holds the two 128-bit state shares, drives them into the round, and sequences the four S-box register stages through the one-hot enable vector. After each round it captures the round output shares back into the state registers, and it iterates `ROUNDS` times per encryption. It also signals the tweakey and randomness sources to advance once per round.

## Interface

Parameters:
- `ROUNDS`, default 40: rounds per encryption; legal range 1..63.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: begin encryption; honoured only while idle.
- `din0`, `din1` in 128: plaintext shares, sampled on the accepted `start` edge.
- `sshi0`, `sshi1` out 128: current state shares, fed to the round function input.
- `ssho0`, `ssho1` in 128: round function output shares (after AddTweakey, ShiftRows, MixColumn).
- `en` out 4: S-box stage enables, one-hot while busy.
- `rnd_idx` out 6: index of the round in progress, 0..ROUNDS-1.
- `rnd_next` out 1: one-cycle pulse in the capture phase of every round. Tweakey-share and randomness sources advance on the edge that ends this pulse.
- `busy` out 1: encryption in progress.
- `done` out 1: one-cycle pulse when the result is valid.
- `dout0`, `dout1` out 128: ciphertext shares; identical to `sshi0`/`sshi1`.

## Operation

- **State registers.** `st0`/`st1` (128 b each) drive `sshi*` and `dout*` directly. There is no combinational path from `din*` or `ssho*` to any output.
- **FSM states.** IDLE, then P0, P1, P2, P3, then CAP. The phase counter is 3 bits.
- **IDLE.**
  - `en`=0, `busy`=0.
  - On `start`=1: `st*` ← `din*`, `rnd_idx` ← 0, go to P0.
- **Phases P0..P3.** `en` = 4'b0001, 4'b0010, 4'b0100, 4'b1000 respectively.
  - `st*` are held constant, because later S-box stages reuse the raw input bits.
- **CAP.**
  - `en`=0, `rnd_next`=1.
  - `st*` ← `ssho*`.
  - If `rnd_idx` == ROUNDS-1: go to IDLE and assert `done` in the following cycle. Otherwise `rnd_idx` increments and the FSM goes to P0.
- **Input stability.**
  - `ksh*` (consumed by the round function) must be valid for round `rnd_idx` during CAP.
  - `r` must be valid and fresh for round `rnd_idx` from P0 through P3.
  - Both are the sources' responsibility; this block only provides `rnd_idx` and `rnd_next`.
- **Masking.** Shares are never XORed together in this block. No unmasked value exists in any register or on any net.
- **`start` handling.**
  - `start` while busy is ignored; there is no queuing and no error.
  - `start` in the same cycle `done` is high is accepted, because the FSM is already IDLE.
- **Result hold.** `dout*` holds the ciphertext shares until the next accepted `start` or reset.

## Timing

- **Reset values.** While `rst` is high, asynchronously: `st0`=`st1`=0, FSM=IDLE, `rnd_idx`=0, `en`=0, `rnd_next`=0, `busy`=0, `done`=0.
- **Cycle numbering.** Let E0 be the edge that accepts `start`. Cycle n is the cycle after edge E0+n.
- **Round k** occupies cycles 5k..5k+4:
  - cycles 5k..5k+3: P0..P3;
  - cycle 5k+4: CAP.
- **`busy`** is high in cycles 0..5·ROUNDS-1.
- **`done`** is high in cycle 5·ROUNDS only; `dout*` is valid from that cycle.
- **Latency.** 5·ROUNDS+1 cycles from the `start` edge to `done`; 201 for ROUNDS=40.
- **Outputs.** All outputs are registered or decoded from the FSM register only.
- **Reset mid-operation.** The encryption aborts immediately, all outputs take their reset values, and no `done` is produced. The first `start` after `rst` falls is accepted normally.

## Test plan

- **Reset.** Assert `rst` with random `din*` and `start`=1 → all outputs 0. Deassert, hold `start`=0 for 10 cycles → `busy`=0, `en`=0.
- **Single encryption.** ROUNDS=40, paired with the round function, tweakey model and PRNG. Use `din0`=random, `din1`=`din0`^plaintext.
  - → `done` exactly in cycle 200.
  - → `dout0`^`dout1` equals the golden SKINNY-128-384+ ciphertext.
  - → Repeat with different share randomness; the unmasked result is identical.
- **Enable sequence.** During any encryption:
  - `en` cycles 1,2,4,8,0 with period 5;
  - `rnd_next` is high exactly when `en`=0 and `busy`=1;
  - `rnd_idx` steps 0..39 in order, changing only after CAP;
  - `sshi*` is constant across P0..P3.
- **`start` while busy.** Pulse `start` with new `din*` in cycles 3 and 77 → no effect on the result, and `done` is still at cycle 200.
- **Back-to-back.** Assert `start` in the same cycle as `done` → a new encryption begins and `done` recurs 201 cycles later. The first result is visible on `dout*` for exactly the `done` cycle.
- **Reset mid-run.** Assert `rst` in cycle 123 → `busy`, `en`, `st*`, `rnd_idx` are 0 in the same cycle and no `done` follows. A subsequent `start` produces the correct ciphertext.

Source files
------------

// File: rtl/dom1_skinny_rnd_ctrl.sv
// ---------------------------------------------------------------------------
// dom1_skinny_rnd_ctrl
//   Round controller and state-share register for the first-order DOM
//   SKINNY-128-384+ datapath. It holds the two state shares and sequences
//   the four S-box register stages with a one-hot enable. It captures the
//   round output shares once per round, and it runs ROUNDS rounds for each
//   encryption.
//
//   Ports
//     clk, rst          : clock (rising edge), asynchronous active-high reset
//     start             : begin encryption (honoured only while idle)
//     din0, din1        : plaintext shares, sampled when start is accepted
//     sshi0, sshi1      : current state shares, feed the round function
//     ssho0, ssho1      : round function output shares
//     en                : S-box stage enables, one-hot during P0..P3
//     rnd_idx           : index of the round in progress
//     rnd_next          : one-cycle pulse in the capture phase of each round
//     busy              : encryption in progress
//     done              : one-cycle pulse when dout0/dout1 are valid
//     dout0, dout1      : ciphertext shares (same registers as sshi0/sshi1)
// ---------------------------------------------------------------------------
module dom1_skinny_rnd_ctrl #(
    parameter int unsigned ROUNDS = 40
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] din0,
    input  logic [127:0] din1,
    output logic [127:0] sshi0,
    output logic [127:0] sshi1,
    input  logic [127:0] ssho0,
    input  logic [127:0] ssho1,
    output logic [3:0]   en,
    output logic [5:0]   rnd_idx,
    output logic         rnd_next,
    output logic         busy,
    output logic         done,
    output logic [127:0] dout0,
    output logic [127:0] dout1
);

    localparam int unsigned IDX_W    = 6;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROUNDS - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_P0   = 3'd1,
        S_P1   = 3'd2,
        S_P2   = 3'd3,
        S_P3   = 3'd4,
        S_CAP  = 3'd5
    } state_t;

    state_t       state;
    logic [127:0] st0;
    logic [127:0] st1;

    // Shares are kept strictly apart: each register only ever loads its own
    // share, so no unmasked value is formed here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            st0      <= '0;
            st1      <= '0;
            rnd_idx  <= '0;
            en       <= '0;
            rnd_next <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            // Pulses default low; every state sets what it needs.
            rnd_next <= 1'b0;
            done     <= 1'b0;
            case (state)
                S_IDLE: begin
                    en <= 4'b0000;
                    if (start) begin
                        st0     <= din0;
                        st1     <= din1;
                        rnd_idx <= '0;
                        en      <= 4'b0001;
                        busy    <= 1'b1;
                        state   <= S_P0;
                    end
                end
                // State shares are held through P0..P3: later S-box stages
                // still consume the raw round input bits.
                S_P0: begin
                    en    <= 4'b0010;
                    state <= S_P1;
                end
                S_P1: begin
                    en    <= 4'b0100;
                    state <= S_P2;
                end
                S_P2: begin
                    en    <= 4'b1000;
                    state <= S_P3;
                end
                S_P3: begin
                    en       <= 4'b0000;
                    rnd_next <= 1'b1;
                    state    <= S_CAP;
                end
                S_CAP: begin
                    st0 <= ssho0;
                    st1 <= ssho1;
                    if (rnd_idx == LAST_IDX) begin
                        en    <= 4'b0000;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= S_IDLE;
                    end else begin
                        rnd_idx <= rnd_idx + IDX_W'(1);
                        en      <= 4'b0001;
                        state   <= S_P0;
                    end
                end
                default: begin
                    en    <= 4'b0000;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign sshi0 = st0;
    assign sshi1 = st1;
    assign dout0 = st0;
    assign dout1 = st1;

endmodule

// File: tb/tb_dom1_skinny_rnd_ctrl.sv
// ---------------------------------------------------------------------------
// tb_dom1_skinny_rnd_ctrl
//   Self-checking bench. A stand-in round function computes ssho* from
//   sshi* and rnd_idx, applying a keyed mix to each share separately. The
//   reference model applies the same round mix to the plaintext shares
//   ROUNDS times and predicts every cycle of the 5-phase schedule.
// ---------------------------------------------------------------------------
module tb_dom1_skinny_rnd_ctrl;

    localparam int unsigned R = 40;

    logic         clk;
    logic         rst;
    logic         start;
    logic [127:0] din0, din1;
    logic [127:0] sshi0, sshi1;
    logic [127:0] ssho0, ssho1;
    logic [3:0]   en;
    logic [5:0]   rnd_idx;
    logic         rnd_next;
    logic         busy;
    logic         done;
    logic [127:0] dout0, dout1;

    int n_checks;
    int n_fail;

    dom1_skinny_rnd_ctrl #(.ROUNDS(R)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .din0     (din0),
        .din1     (din1),
        .sshi0    (sshi0),
        .sshi1    (sshi1),
        .ssho0    (ssho0),
        .ssho1    (ssho1),
        .en       (en),
        .rnd_idx  (rnd_idx),
        .rnd_next (rnd_next),
        .busy     (busy),
        .done     (done),
        .dout0    (dout0),
        .dout1    (dout1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Per-share round mix: rotate, add a round-dependent constant and a
    // share-specific constant. Works on one share only.
    function automatic logic [127:0] rmix(input logic [127:0] x, input int unsigned k, input bit s);
        logic [127:0] rc;
        rc = 128'(k + 1) * 128'h9E3779B97F4A7C15F39CC0605CEDC834;
        rmix = {x[120:0], x[127:121]} ^ rc ^ (s ? 128'hA5A5A5A5_0F0F0F0F_3C3C3C3C_5A5A5A5A : 128'h0);
    endfunction

    always_comb begin
        ssho0 = rmix(sshi0, 32'(rnd_idx), 1'b0);
        ssho1 = rmix(sshi1, 32'(rnd_idx), 1'b1);
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] rnd128();
        rnd128 = {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [3:0] en_for_phase(input int unsigned ph);
        logic [3:0] onehot;
        onehot = 4'b0001;
        en_for_phase = (ph < 4) ? (onehot << ph) : 4'b0000;
    endfunction

    // Drive start with the given shares; returns in cycle 0 (after E0).
    task automatic launch(input logic [127:0] d0, input logic [127:0] d1);
        din0  = d0;
        din1  = d1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        din0  = rnd128();
        din1  = rnd128();
    endtask

    // Follow one encryption from cycle 0, checking every cycle against the
    // model. Optionally pulses start while busy, chains a new start on the
    // done cycle, or asserts reset in cycle abort_at and returns.
    task automatic track(input logic [127:0] d0, input logic [127:0] d1,
                         input bit busy_starts, input bit chain,
                         input logic [127:0] nd0, input logic [127:0] nd1,
                         input int abort_at);
        logic [127:0] cur0, cur1;
        int unsigned  k, ph;
        cur0 = d0;
        cur1 = d1;
        for (int n = 0; n < int'(5 * R); n++) begin
            k  = 32'(n) / 5;
            ph = 32'(n) % 5;
            if (n == abort_at) begin
                rst = 1'b1;
                #1;
                check("abort_busy",  128'(busy), 128'(0));
                check("abort_en",    128'(en), 128'(0));
                check("abort_sshi0", sshi0, 128'(0));
                check("abort_sshi1", sshi1, 128'(0));
                check("abort_idx",   128'(rnd_idx), 128'(0));
                check("abort_done",  128'(done), 128'(0));
                return;
            end
            check("busy",     128'(busy), 128'(1));
            check("done_lo",  128'(done), 128'(0));
            check("en",       128'(en), 128'(en_for_phase(ph)));
            check("rnd_idx",  128'(rnd_idx), 128'(k));
            check("rnd_next", 128'(rnd_next), 128'(ph == 4));
            check("sshi0",    sshi0, cur0);
            check("sshi1",    sshi1, cur1);
            if (ph == 4) begin
                cur0 = rmix(cur0, k, 1'b0);
                cur1 = rmix(cur1, k, 1'b1);
            end
            if (busy_starts && (n == 3 || n == 77)) begin
                din0  = rnd128();
                din1  = rnd128();
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        // cycle 5*R
        check("done",      128'(done), 128'(1));
        check("busy_end",  128'(busy), 128'(0));
        check("en_end",    128'(en), 128'(0));
        check("dout0",     dout0, cur0);
        check("dout1",     dout1, cur1);
        check("dout_xor",  dout0 ^ dout1, cur0 ^ cur1);
        if (chain) begin
            launch(nd0, nd1);
        end else begin
            @(posedge clk);
            #1;
            check("done_once",  128'(done), 128'(0));
            check("hold_dout0", dout0, cur0);
            check("hold_dout1", dout1, cur1);
        end
    endtask

    initial begin
        logic [127:0] a0, a1, b0, b1, pt, m;
        n_checks = 0;
        n_fail   = 0;

        // Reset with start asserted and random inputs
        rst   = 1'b1;
        start = 1'b1;
        din0  = rnd128();
        din1  = rnd128();
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy",  128'(busy), 128'(0));
        check("rst_en",    128'(en), 128'(0));
        check("rst_done",  128'(done), 128'(0));
        check("rst_next",  128'(rnd_next), 128'(0));
        check("rst_idx",   128'(rnd_idx), 128'(0));
        check("rst_dout0", dout0, 128'(0));
        check("rst_dout1", dout1, 128'(0));
        rst   = 1'b0;
        start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check("idle_busy", 128'(busy), 128'(0));
            check("idle_en",   128'(en), 128'(0));
        end

        // Same plaintext under two maskings
        pt = rnd128();
        a0 = rnd128();
        a1 = a0 ^ pt;
        launch(a0, a1);
        track(a0, a1, 1'b0, 1'b0, '0, '0, -1);
        m  = dout0 ^ dout1;
        b0 = rnd128();
        b1 = b0 ^ pt;
        launch(b0, b1);
        track(b0, b1, 1'b0, 1'b0, '0, '0, -1);
        // The mask-dependent rotations commute with XOR; only the share
        // constant survives, so the unmasked result is mask independent.
        check("unmasked_same", dout0 ^ dout1, m);

        // start pulses while busy are ignored
        a0 = rnd128();
        a1 = rnd128();
        launch(a0, a1);
        track(a0, a1, 1'b1, 1'b0, '0, '0, -1);

        // Back-to-back: start on the done cycle
        a0 = rnd128();
        a1 = rnd128();
        b0 = rnd128();
        b1 = rnd128();
        launch(a0, a1);
        track(a0, a1, 1'b0, 1'b1, b0, b1, -1);
        track(b0, b1, 1'b0, 1'b0, '0, '0, -1);

        // Reset in cycle 123, then no done
        a0 = rnd128();
        a1 = rnd128();
        launch(a0, a1);
        track(a0, a1, 1'b0, 1'b0, '0, '0, 123);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 250; i++) begin
            @(posedge clk);
            #1;
            check("no_done_after_abort", 128'(done | busy), 128'(0));
        end

        // Fresh encryptions after the abort
        for (int t = 0; t < 3; t++) begin
            a0 = rnd128();
            a1 = rnd128();
            launch(a0, a1);
            track(a0, a1, 1'b0, 1'b0, '0, '0, -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
